// File: rtl/icache_refill_controller.sv
// Instruction-cache miss handler: fetches a 4-word line from memory, assembles it, writes it to the cache.
// Latency is miss cycle + REQ until grant + one cycle per beat + WRITE; stall holds fetch for the whole refill.
module icache_refill_controller #(
    parameter int TIMEOUT    = 255,
    parameter int LINE_WORDS = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [31:0]              fetch_addr,
    input  logic                     fetch_valid,
    input  logic                     cache_hit,
    output logic                     stall,
    output logic                     mem_req,
    output logic [31:0]              mem_addr,
    input  logic                     mem_gnt,
    input  logic                     mem_rvalid,
    input  logic [31:0]              mem_rdata,
    output logic [32*LINE_WORDS-1:0] line_out,
    output logic [31:0]              fill_addr,
    output logic                     line_we,
    output logic                     err
);

    localparam int                TW       = $clog2(TIMEOUT + 1);
    localparam int                CW       = $clog2(LINE_WORDS);
    localparam logic [TW-1:0]     TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [CW-1:0]     CNT_LAST = CW'(LINE_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_FILL  = 3'd2,
        S_WRITE = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    state_t                    r_state;
    logic [CW-1:0]             r_cnt;
    logic [TW-1:0]             r_tmo;
    logic [31:0]               r_fill_addr;
    logic [32*LINE_WORDS-1:0]  r_line;
    logic                      r_mem_req;
    logic                      r_line_we;
    logic                      r_err;

    logic                      w_miss;
    logic [31:0]               w_line_addr;

    assign w_miss      = fetch_valid && !cache_hit;
    assign w_line_addr = fetch_addr & ~32'h0000_000F;

    // The miss cycle itself must stall, so the IDLE term is combinational.
    assign stall     = (r_state != S_IDLE) || w_miss;
    assign mem_req   = r_mem_req;
    assign mem_addr  = r_fill_addr;
    assign fill_addr = r_fill_addr;
    assign line_out  = r_line;
    assign line_we   = r_line_we;
    assign err       = r_err;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_tmo       <= '0;
            r_fill_addr <= '0;
            r_line      <= '0;
            r_mem_req   <= 1'b0;
            r_line_we   <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_miss) begin
                        r_fill_addr <= w_line_addr;
                        r_cnt       <= '0;
                        r_tmo       <= '0;
                        r_mem_req   <= 1'b1;
                        r_state     <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (mem_gnt) begin
                        r_tmo     <= '0;
                        r_mem_req <= 1'b0;
                        r_state   <= S_FILL;
                    end else if (r_tmo == TMO_LAST) begin
                        r_mem_req <= 1'b0;
                        r_err     <= 1'b1;
                        r_state   <= S_ERR;
                    end else begin
                        r_tmo <= r_tmo + TW'(1);
                    end
                end
                S_FILL: begin
                    if (mem_rvalid) begin
                        r_line[32*r_cnt +: 32] <= mem_rdata;
                        r_cnt                  <= r_cnt + CW'(1);
                        r_tmo                  <= '0;
                        if (r_cnt == CNT_LAST) begin
                            r_line_we <= 1'b1;
                            r_state   <= S_WRITE;
                        end
                    end else if (r_tmo == TMO_LAST) begin
                        r_err   <= 1'b1;
                        r_state <= S_ERR;
                    end else begin
                        r_tmo <= r_tmo + TW'(1);
                    end
                end
                S_WRITE: begin
                    r_line_we <= 1'b0;
                    r_state   <= S_IDLE;
                end
                S_ERR: begin
                    // Only reset leaves the error state.
                    r_state <= S_ERR;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_icache_refill_controller.sv
// Randomised and directed bench for icache_refill_controller against a transaction-level model.
module tb_icache_refill_controller;

    localparam int TIMEOUT = 255;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [31:0]  fetch_addr = '0;
    logic         fetch_valid = 1'b0;
    logic         cache_hit = 1'b0;
    logic         stall;
    logic         mem_req;
    logic [31:0]  mem_addr;
    logic         mem_gnt = 1'b0;
    logic         mem_rvalid = 1'b0;
    logic [31:0]  mem_rdata = '0;
    logic [127:0] line_out;
    logic [31:0]  fill_addr;
    logic         line_we;
    logic         err;

    icache_refill_controller #(.TIMEOUT(TIMEOUT), .LINE_WORDS(4)) dut (
        .clk(clk), .rst(rst), .fetch_addr(fetch_addr), .fetch_valid(fetch_valid),
        .cache_hit(cache_hit), .stall(stall), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .line_out(line_out), .fill_addr(fill_addr), .line_we(line_we), .err(err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference model: a miss becomes a transaction that waits for a grant,
    // collects four words in arrival order, then writes once.
    int          m_phase = 0;   // 0 idle, 1 awaiting grant, 2 collecting, 3 writing, 4 dead
    int          m_waits = 0;
    logic [31:0] m_words[$];
    logic [31:0] m_line[4] = '{default: 32'h0};
    logic [31:0] m_fill = '0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_phase = 0; m_waits = 0; m_fill = '0;
            m_words.delete();
            for (int i = 0; i < 4; i++) m_line[i] = '0;
        end else begin
            case (m_phase)
                0: if (fetch_valid && !cache_hit) begin
                       m_fill  = {fetch_addr[31:4], 4'h0};
                       m_waits = 0;
                       m_words.delete();
                       m_phase = 1;
                   end
                1: if (mem_gnt) begin
                       m_phase = 2; m_waits = 0;
                   end else begin
                       m_waits++;
                       if (m_waits == TIMEOUT) m_phase = 4;
                   end
                2: if (mem_rvalid) begin
                       m_line[m_words.size()] = mem_rdata;
                       m_words.push_back(mem_rdata);
                       m_waits = 0;
                       if (m_words.size() == 4) m_phase = 3;
                   end else begin
                       m_waits++;
                       if (m_waits == TIMEOUT) m_phase = 4;
                   end
                3: m_phase = 0;
                default: m_phase = 4;
            endcase
        end
    end

    always @(negedge clk) begin
        #1;
        check("stall",     stall,     (m_phase != 0) || (fetch_valid && !cache_hit));
        check("mem_req",   mem_req,   m_phase == 1);
        check("mem_addr",  mem_addr,  m_fill);
        check("fill_addr", fill_addr, m_fill);
        check("line_we",   line_we,   m_phase == 3);
        check("err",       err,       m_phase == 4);
        check("line_out",  line_out,  {m_line[3], m_line[2], m_line[1], m_line[0]});
    end

    // Monitor of observed DUT activity for the directed checks.
    int          we_cnt = 0;
    int          req_cnt = 0;
    logic [31:0] we_addr[4];
    logic [31:0] last_req_addr = 32'hDEAD_BEEF;

    always @(negedge clk) begin
        #2;
        if (line_we) begin
            if (we_cnt < 4) we_addr[we_cnt] = fill_addr;
            we_cnt++;
        end
        if (mem_req) begin
            req_cnt++;
            last_req_addr = mem_addr;
        end
    end

    // Memory agent: grants after a_dly REQ cycles, then returns four beats with gaps.
    int          a_dly = 0, a_gap_fixed = 0, a_gap_max = 0;
    bit          a_withhold = 0, a_noise = 0, a_rand_data = 0;
    logic [31:0] a_data[4];
    int          a_beats_given = 0;
    int          a_wait = 0, a_beat = 0, a_gapcnt = 0;
    bit          a_active = 0;

    function automatic int next_gap();
        return (a_gap_fixed >= 0) ? a_gap_fixed : int'($urandom_range(a_gap_max));
    endfunction

    always @(negedge clk) begin
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = $urandom;
        if (!rst) begin
            a_active = 0; a_wait = 0;
        end else if (a_active) begin
            if (a_gapcnt > 0) a_gapcnt--;
            else begin
                mem_rvalid = 1'b1;
                mem_rdata  = a_rand_data ? $urandom : a_data[a_beat];
                a_beat++;
                a_beats_given++;
                a_gapcnt = next_gap();
                if (a_beat == 4) a_active = 0;
            end
        end else if (mem_req && !a_withhold) begin
            if (a_wait >= a_dly) begin
                mem_gnt  = 1'b1;
                a_active = 1; a_beat = 0; a_wait = 0;
                a_gapcnt = next_gap();
            end else a_wait++;
        end else begin
            a_wait = 0;
            if (a_noise && $urandom_range(3) == 0) mem_rvalid = 1'b1;
        end
    end

    task automatic clear_mon();
        we_cnt = 0; req_cnt = 0; a_beats_given = 0;
        last_req_addr = 32'hDEAD_BEEF;
    endtask

    task automatic wait_we(input int n, input int budget);
        for (int i = 0; i < budget && we_cnt < n; i++) begin
            @(negedge clk); #3;
        end
    endtask

    task automatic set_data(input logic [31:0] d0, d1, d2, d3);
        a_data[0] = d0; a_data[1] = d1; a_data[2] = d2; a_data[3] = d3;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        #1;
        check("reset_stall",   stall, 0);
        check("reset_mem_req", mem_req, 0);
        check("reset_line",    line_out, 0);
        check("reset_err",     err, 0);
        @(negedge clk); #3 rst = 1'b1;

        // Miss at 0x8, grant after 2 cycles, fixed beat data.
        a_dly = 2; a_gap_fixed = 0; a_noise = 0; a_rand_data = 0;
        set_data(32'h0000_7C00, 32'hFFFF_FFFF, 32'h0000_0000, 32'hFFFF_FFFF);
        @(negedge clk); clear_mon();
        fetch_addr = 32'h8; fetch_valid = 1; cache_hit = 0;
        @(negedge clk); fetch_valid = 0;
        wait_we(1, 40);
        repeat (3) @(negedge clk);
        #3;
        check("t1_mem_addr",  last_req_addr, 32'h0);
        check("t1_req_cycles", req_cnt, 3);
        check("t1_line", line_out, 128'hFFFFFFFF_00000000_FFFFFFFF_00007C00);
        check("t1_we_count", we_cnt, 1);
        check("t1_fill_addr", fill_addr, 32'h0);

        // Hit at 0x1.
        @(negedge clk); clear_mon();
        fetch_addr = 32'h1; fetch_valid = 1; cache_hit = 1;
        #1 check("t2_stall", stall, 0);
        repeat (5) @(negedge clk);
        #3 check("t2_no_req", req_cnt, 0);
        fetch_valid = 0;

        // Gapped beats with fetch inputs moving mid-fill.
        a_dly = 1; a_gap_fixed = 3;
        set_data(32'hAAAA_0001, 32'hAAAA_0002, 32'hAAAA_0003, 32'hAAAA_0004);
        @(negedge clk); clear_mon();
        fetch_addr = 32'h0; fetch_valid = 1; cache_hit = 0;
        @(negedge clk); fetch_valid = 0;
        for (int i = 0; i < 40 && a_beats_given < 1; i++) begin @(negedge clk); #3; end
        fetch_addr = 32'h40; fetch_valid = 1; cache_hit = 1;
        wait_we(1, 60);
        #1 check("t3_fill_addr", fill_addr, 32'h0);
        @(negedge clk); fetch_valid = 0;
        repeat (4) @(negedge clk);
        #3;
        check("t3_line", line_out, 128'hAAAA0004_AAAA0003_AAAA0002_AAAA0001);
        check("t3_we_count", we_cnt, 1);

        // Back-to-back misses: 0x00 then 0x20 in the first IDLE cycle.
        a_dly = 0; a_gap_fixed = 0;
        set_data(32'h1, 32'h2, 32'h3, 32'h4);
        @(negedge clk); clear_mon();
        fetch_addr = 32'h0; fetch_valid = 1; cache_hit = 0;
        for (int i = 0; i < 40 && !line_we; i++) begin @(negedge clk); #3; end
        fetch_addr = 32'h20;
        @(negedge clk); #3;
        @(negedge clk); #3 fetch_valid = 0;
        wait_we(2, 40);
        #1;
        check("t6_we_count", we_cnt, 2);
        if (we_cnt >= 2) begin
            check("t6_first_addr",  we_addr[0], 32'h0);
            check("t6_second_addr", we_addr[1], 32'h20);
        end

        // Grant withheld until timeout.
        @(negedge clk); clear_mon(); a_withhold = 1;
        fetch_addr = 32'h0012_3456; fetch_valid = 1; cache_hit = 0;
        @(negedge clk); fetch_valid = 0;
        repeat (270) @(negedge clk);
        #3;
        check("t4_err", err, 1);
        check("t4_stall", stall, 1);
        check("t4_mem_req", mem_req, 0);
        check("t4_req_cycles", req_cnt, TIMEOUT);
        check("t4_no_we", we_cnt, 0);
        rst = 0;
        @(negedge clk); #3 rst = 1; a_withhold = 0;
        #1 check("t4_err_cleared", err, 0);

        // Reset after the second beat, then a clean refill at 0x10.
        a_dly = 0; a_gap_fixed = 1;
        set_data(32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444);
        @(negedge clk); clear_mon();
        fetch_addr = 32'h0; fetch_valid = 1; cache_hit = 0;
        @(negedge clk); fetch_valid = 0;
        for (int i = 0; i < 40 && a_beats_given < 2; i++) begin @(negedge clk); #3; end
        @(negedge clk); #2;
        check("t5_partial_line", line_out, 128'h0_0_22222222_11111111);
        #1 rst = 0;
        #1;
        check("t5_rst_mem_req", mem_req, 0);
        check("t5_rst_line", line_out, 0);
        check("t5_rst_fill_addr", fill_addr, 0);
        check("t5_rst_stall", stall, 0);
        check("t5_rst_no_we", we_cnt, 0);
        @(negedge clk); #3 rst = 1;
        @(negedge clk); clear_mon();
        fetch_addr = 32'h1C; fetch_valid = 1; cache_hit = 0;
        @(negedge clk); fetch_valid = 0;
        wait_we(1, 40);
        #1;
        check("t5_mem_addr", last_req_addr, 32'h10);
        check("t5_fill_addr", fill_addr, 32'h10);
        check("t5_line", line_out, 128'h44444444_33333333_22222222_11111111);
        check("t5_we_count", we_cnt, 1);

        // Random traffic with spurious rvalid outside refills.
        a_noise = 1; a_gap_fixed = -1; a_gap_max = 4; a_rand_data = 1;
        @(negedge clk); clear_mon();
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            a_dly       = $urandom_range(4);
            fetch_valid = $urandom_range(1);
            cache_hit   = ($urandom_range(2) != 0);
            fetch_addr  = $urandom;
        end
        @(negedge clk); fetch_valid = 0;
        repeat (40) @(negedge clk);
        #3;
        check("rand_no_err", err, 0);
        check("rand_progress", we_cnt > 0, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
